cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Run/step controller for the multi-cycle CPU. It replaces the gated debug-clock mux with a single-clock clock-enable (cpu_en) and supports four modes: free run, cycle step, instruction step and run-to-breakpoint. It also keeps cycle and retired-instruction counters. It sits between the debounced button/switch logic and the CPU datapath/control, whose sequential elements all use cpu_en.

Parameters:
PC_W, 32, width of pc and bp_addr
CNT_W, 16, width of cycle_cnt and instr_cnt (wrap-around)
BEAT_W, 5, width of one-hot beat vector from control FSM; beat[0] = fetch beat
MAX_BEATS, 8, max enabled cycles per instruction step before fault

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mode  in  2  00 run, 01 cycle-step, 10 instr-step, 11 run-to-breakpoint
step_pulse  in  1  one-cycle pulse from debouncer
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current CPU PC
beat  in  BEAT_W  current one-hot CPU beat
cnt_clr  in  1  synchronous counter clear
cpu_en  out  1  CPU clock enable (combinational from state/inputs)
halted  out  1  state == HALT
state  out  2  HALT=00, RUN=01, STEP_CYC=10, STEP_INS=11
step_fault  out  1  sticky: instruction step exceeded MAX_BEATS
cycle_cnt  out  CNT_W  enabled-cycle count
instr_cnt  out  CNT_W  retired-fetch count

Behaviour:
- Reset: state HALT, cpu_en 0, counters 0, step_fault 0, internal skip/first flags 0, beat-step counter 0. Reset during any step or run forces HALT on the next edge.
- bp_hit = mode==11 & bp_en & beat[0] & pc==bp_addr & !skip.
- cpu_en:
  - RUN: (mode==00 | mode==11) & !bp_hit
  - STEP_CYC: 1
  - STEP_INS: first | !beat[0]
  - HALT: 0
- HALT:
  - mode 00: next state RUN.
  - mode 01 & step_pulse: STEP_CYC.
  - mode 10 & step_pulse: STEP_INS, set first=1, beat-step counter=0.
  - mode 11 & step_pulse: RUN with skip=1.
  - Otherwise stay in HALT.
- RUN:
  - mode 01 or 10: HALT (cpu_en already 0 this cycle).
  - bp_hit: HALT (the fetch at bp_addr is not executed).
  - skip clears after the first cycle with cpu_en=1.
- STEP_CYC: exactly one enabled cycle, then HALT.
- STEP_INS:
  - first clears after the first enabled cycle.
  - When !first & beat[0]: HALT, cpu_en 0 in that cycle (CPU parked at the next fetch).
  - Beat-step counter increments per enabled cycle. On reaching MAX_BEATS: set step_fault, go to HALT.
- step_pulse is ignored outside HALT. A mode change during STEP_CYC/STEP_INS does not abort the step.
- Counters:
  - cycle_cnt +1 every cycle cpu_en=1.
  - instr_cnt +1 when cpu_en & beat[0].
  - Both wrap modulo 2^CNT_W.
  - cnt_clr zeroes both counters and step_fault; clr wins over a simultaneous increment.
- No output depends on anything other than the registered state, flags and current inputs. No gated clocks.

Decomposition:
- Shared package cpu_dbg_pkg: mode encodings (MODE_RUN/CYC/INS/BRK), state encodings (ST_HALT/RUN/STEP_CYC/STEP_INS), BEAT_FETCH index 0.
- One natural sub-module: dbg_counter (parametrised width, enable, sync clear, wrap), instanced twice for cycle_cnt and instr_cnt.

Test Plan:
- Reset with mode=00, hold rst 3 cycles, release → halted=1 during rst; state=RUN and cpu_en=1 from the second cycle after release; cycle_cnt=5 after 5 enabled cycles.
- mode=01, halted, one step_pulse → exactly one cycle with cpu_en=1, back to HALT, cycle_cnt +1, instr_cnt +1 only if beat=5'b00001 on that cycle.
- mode=10, beat sequence 00001,00010,00100,01000,00001 with step_pulse → cpu_en high 4 cycles, low when beat=00001 again, halted=1, instr_cnt +1, cycle_cnt +4.
- mode=11, bp_en=1, bp_addr=0x0000_0010, pc reaches 0x10 with beat[0]=1 → cpu_en=0 that cycle, halted=1. step_pulse → resumes, executes fetch at 0x10, instr_cnt +1.
- mode=10, beat stuck at 00010 (never returns to fetch) → after 8 enabled cycles step_fault=1, halted=1. cnt_clr → step_fault=0, counters=0.
- CNT_W=4: run 16 fetch cycles → instr_cnt wraps 15→0. cnt_clr coinciding with an increment → counter reads 0 next cycle.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run/step controller: operating modes, controller
// states and the beat index that marks an instruction fetch.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_RUN = 2'b00,
        MODE_CYC = 2'b01,
        MODE_INS = 2'b10,
        MODE_BRK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_HALT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_STEP_CYC = 2'b10,
        ST_STEP_INS = 2'b11
    } state_e;

    localparam int BEAT_FETCH = 0;

endpackage

// File: rtl/dbg_counter.sv
// Wrap-around event counter with enable and synchronous clear; clear takes
// priority over a simultaneous increment.
module dbg_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // NOTE: state is updated with non-blocking assignments only, so every
    // clocked block sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: produces the single-clock CPU enable for free run, cycle
// step, instruction step and run-to-breakpoint, plus cycle/instruction counters.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int CNT_W     = 16,
    parameter int BEAT_W    = 5,
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              step_pulse,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic [BEAT_W-1:0] beat,
    input  logic              cnt_clr,
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic              step_fault,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int BC_W = $clog2(MAX_BEATS + 1);

    mode_e            mode_sel;
    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic             skip_q, skip_d;
    logic             fault_q, fault_set;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic             fetch;
    logic             bp_hit;

    // Only the fetch bit of the beat vector matters here.
    logic unused_beat;
    assign unused_beat = ^beat;

    assign mode_sel = mode_e'(mode);
    assign fetch    = beat[BEAT_FETCH];
    assign bp_hit   = (mode_sel == MODE_BRK) && bp_en && fetch
                      && (pc == bp_addr) && !skip_q;

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        skip_d    = skip_q;
        bcnt_d    = bcnt_q;
        fault_set = 1'b0;
        cpu_en    = 1'b0;

        case (state_q)
            ST_HALT: begin
                case (mode_sel)
                    MODE_RUN: state_d = ST_RUN;
                    MODE_CYC: if (step_pulse) state_d = ST_STEP_CYC;
                    MODE_INS: begin
                        if (step_pulse) begin
                            state_d = ST_STEP_INS;
                            first_d = 1'b1;
                            bcnt_d  = '0;
                        end
                    end
                    MODE_BRK: begin
                        if (step_pulse) begin
                            state_d = ST_RUN;
                            skip_d  = 1'b1;
                        end
                    end
                    default: state_d = ST_HALT;
                endcase
            end

            ST_RUN: begin
                cpu_en = ((mode_sel == MODE_RUN) || (mode_sel == MODE_BRK)) && !bp_hit;
                if ((mode_sel == MODE_CYC) || (mode_sel == MODE_INS) || bp_hit) begin
                    state_d = ST_HALT;
                end
                // The breakpoint is re-armed once the resumed fetch has executed.
                if (cpu_en) skip_d = 1'b0;
            end

            ST_STEP_CYC: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end

            ST_STEP_INS: begin
                if (!first_q && fetch) begin
                    // Park the CPU on the next fetch without executing it.
                    state_d = ST_HALT;
                end else begin
                    cpu_en  = 1'b1;
                    first_d = 1'b0;
                    bcnt_d  = bcnt_q + BC_W'(1);
                    if (bcnt_q == BC_W'(MAX_BEATS - 1)) begin
                        fault_set = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end

            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            first_q <= 1'b0;
            skip_q  <= 1'b0;
            bcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            skip_q  <= skip_d;
            bcnt_q  <= bcnt_d;
            if (cnt_clr) begin
                fault_q <= 1'b0;
            end else if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign halted     = (state_q == ST_HALT);
    assign state      = state_q;
    assign step_fault = fault_q;

    dbg_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cpu_en),
        .clr   (cnt_clr),
        .count (cycle_cnt)
    );

    dbg_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cpu_en && fetch),
        .clr   (cnt_clr),
        .count (instr_cnt)
    );

endmodule
